voice_vca_mixer: RTL and testbench
==================================

# voice_vca_mixer

Consumer side of the per-voice envelope interface: takes each voice's signed oscillator sample and its 8-bit envelope amplitude, applies `sample = (osc * env) >>> 8`, and sums all voices into one saturated 16-bit mix sample per 48 kHz period. It sits between the voice array (oscillator plus envelope generator per voice) and the output DAC serializer. It uses a single time-multiplexed shift-add multiplier, not one multiplier per voice.

## Interface

Parameters:
- `NUM_VOICES`, 4: number of voices mixed. Legal range 1..100, so processing fits within one 1024-clk sample period.

Ports:
- `clk` in 1: 49.152 MHz audio clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `sample_strobe` in 1: one-clk pulse every 48 kHz period; starts a mix pass.
- `osc_in` in 16*NUM_VOICES: packed signed two's-complement oscillator samples; voice v at bits [16v+15:16v].
- `env_in` in 8*NUM_VOICES: packed unsigned envelope amplitudes (0-255); voice v at bits [8v+7:8v].
- `voice_enable` in NUM_VOICES: bit v=0 forces voice v's contribution to 0.
- `mix_out` out 16: signed saturated mix; holds its value between passes.
- `mix_valid` out 1: one-clk pulse when `mix_out` updates.
- `busy` out 1: high while a pass is in progress.
- `overrun` out 1: sticky; set when `sample_strobe` arrives while busy. Cleared only by reset.

## Operation

- States: IDLE, MUL, ACC, DONE.
- IDLE: on `sample_strobe`, snapshot all of `osc_in`, `env_in` and `voice_enable` into internal registers in the same edge. Then clear the accumulator, set voice index 0 and bit index 0, and go to MUL.
- MUL: 8 cycles per voice, bit k = 0..7 in LSB-first order.
  - If snapshot env bit k is 1, add the sign-extended osc shifted left by k into a 24-bit signed partial product. The partial product is cleared at voice start.
- ACC: one cycle.
  - Scaled value = partial product >>> 8 (arithmetic shift, floor toward minus infinity), kept as 16 bits signed.
  - If the snapshot enable bit for this voice is 1, add the scaled value to the accumulator.
  - Accumulator width is 16 + ceil(log2(NUM_VOICES)) + 1 bits signed; it never wraps.
  - If this is the last voice, go to DONE. Otherwise advance the voice index, set bit index 0, and go to MUL.
- DONE: saturate the accumulator to [-32768, 32767], register the result into `mix_out`, pulse `mix_valid`, then return to IDLE.
- Disabled voices still consume their 9 cycles, so latency is fixed regardless of `voice_enable`.
- Input changes after the snapshot edge have no effect on the pass in progress.
- Strobe while busy (any state other than IDLE): the strobe is ignored, `overrun` is set, and the current pass continues unaffected.
- Reset (async, mid-pass or otherwise): state goes to IDLE and all outputs and snapshots are zeroed immediately. A pass interrupted by reset produces no `mix_valid`.

## Timing

- Reset values: `mix_out`=0, `mix_valid`=0, `busy`=0, `overrun`=0.
- Edge 0 is the edge that samples `sample_strobe`=1 in IDLE.
- Voice v occupies MUL during cycles 9v+1 through 9v+8 and ACC during cycle 9v+9.
- DONE occupies cycle 9N+1.
- `mix_out` and `mix_valid` become visible after edge 9N+1. For N=4 that is edge 37: `mix_valid` is high for exactly one cycle, and `mix_out` is stable from then on.
- `busy` is high from edge 0 up to the edge that returns to IDLE.
- A strobe in the cycle immediately after `mix_valid` is accepted.
- Pass length is 9N+2 clks, well below the 1024-clk strobe spacing.

## Test plan

- N=4, v0 osc=32767 env=255, voices 1-3 disabled, strobe -> `mix_out`=32639, with `mix_valid` a single pulse 37 edges after the strobe edge.
- All four voices osc=32767 env=255 -> 32767 (saturated from 130556). All four osc=-32768 env=255 -> -32768 (from -130560).
- Mixed case -> `mix_out`=349:
  - v0 1000/128 -> 500
  - v1 -600/64 -> -150
  - v2 -1/1 -> -1 (floor)
  - v3 32767/255 with enable=0 -> 0
- Change `osc_in`/`env_in` and re-strobe at edge 10 of a pass -> result equals the first snapshot's mix, `overrun`=1 and stays 1, and no second `mix_valid` occurs.
- Assert `rst_n`=0 at edge 20 of a pass -> outputs are 0 immediately and no `mix_valid`. After release, the next strobe produces the correct mix at +37.
- Strobes every 1024 clks for 8 periods with a ramping env -> exactly one `mix_valid` per period, values match the reference model, and `overrun` stays 0.

Source files
------------

// File: rtl/voice_vca_mixer.sv
// Per-voice VCA and mixer: one shared shift-add multiplier scales each voice's
// oscillator by its envelope, then sums the voices into a saturated 16-bit mix.
module voice_vca_mixer #(
   parameter int NUM_VOICES = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      sample_strobe,
   input  logic [16*NUM_VOICES-1:0]  osc_in,
   input  logic [8*NUM_VOICES-1:0]   env_in,
   input  logic [NUM_VOICES-1:0]     voice_enable,
   output logic [15:0]               mix_out,
   output logic                      mix_valid,
   output logic                      busy,
   output logic                      overrun
);

   localparam int AW = 16 + $clog2(NUM_VOICES) + 1;
   localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [VW-1:0] LAST_VOICE = VW'(NUM_VOICES - 1);
   localparam logic signed [AW-1:0] MIX_MAX = AW'(32767);
   localparam logic signed [AW-1:0] MIX_MIN = -AW'(32768);

   typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;
   state_t state_reg, state_next;

   logic [16*NUM_VOICES-1:0] osc_snap_reg;
   logic [8*NUM_VOICES-1:0]  env_snap_reg;
   logic [NUM_VOICES-1:0]    en_snap_reg;
   logic [VW-1:0]            voice_reg;
   logic [2:0]               bit_reg;
   logic signed [23:0]       prod_reg;
   logic signed [AW-1:0]     acc_reg;

   logic signed [15:0] osc_arr [NUM_VOICES];
   logic [7:0]         env_arr [NUM_VOICES];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_VOICES; gi++) begin : g_unpack
         assign osc_arr[gi] = osc_snap_reg[16*gi +: 16];
         assign env_arr[gi] = env_snap_reg[8*gi +: 8];
      end
   endgenerate

   logic signed [15:0] cur_osc;
   logic [7:0]         cur_env;
   logic               cur_en;
   logic signed [23:0] addend;
   logic signed [AW-1:0] scaled;
   logic [15:0]        sat_val;

   assign cur_osc = osc_arr[voice_reg];
   assign cur_env = env_arr[voice_reg];
   assign cur_en  = en_snap_reg[voice_reg];
   assign addend  = {{8{cur_osc[15]}}, cur_osc} <<< bit_reg;
   // The product always fits in 16 signed bits after the shift, so narrowing
   // (or matching) to AW keeps the exact floored value.
   assign scaled  = AW'(prod_reg >>> 8);
   assign busy    = (state_reg != IDLE);

   always_comb begin
      sat_val = acc_reg[15:0];
      if (acc_reg > MIX_MAX)
         sat_val = 16'h7FFF;
      else if (acc_reg < MIX_MIN)
         sat_val = 16'h8000;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (sample_strobe) state_next = MUL;
         MUL:  if (bit_reg == 3'd7) state_next = ACC;
         ACC:  state_next = (voice_reg == LAST_VOICE) ? DONE : MUL;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         osc_snap_reg <= '0;
         env_snap_reg <= '0;
         en_snap_reg  <= '0;
         voice_reg    <= '0;
         bit_reg      <= '0;
         prod_reg     <= '0;
         acc_reg      <= '0;
         mix_out      <= '0;
         mix_valid    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         mix_valid <= 1'b0;
         if (sample_strobe && state_reg != IDLE)
            overrun <= 1'b1;
         case (state_reg)
            IDLE: begin
               if (sample_strobe) begin
                  osc_snap_reg <= osc_in;
                  env_snap_reg <= env_in;
                  en_snap_reg  <= voice_enable;
                  acc_reg      <= '0;
                  voice_reg    <= '0;
                  bit_reg      <= '0;
                  prod_reg     <= '0;
               end
            end
            MUL: begin
               if (cur_env[bit_reg])
                  prod_reg <= prod_reg + addend;
               bit_reg <= bit_reg + 3'd1;
            end
            ACC: begin
               if (cur_en)
                  acc_reg <= acc_reg + scaled;
               if (voice_reg != LAST_VOICE)
                  voice_reg <= voice_reg + VW'(1);
               bit_reg  <= '0;
               prod_reg <= '0;
            end
            DONE: begin
               mix_out   <= sat_val;
               mix_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_voice_vca_mixer.sv
// Directed and randomized checks of voice_vca_mixer against an arithmetic
// reference model of the scaled-and-saturated voice mix.
module tb_voice_vca_mixer;
   localparam int N = 4;
   localparam int LAT = 9 * N + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              sample_strobe;
   logic [16*N-1:0]   osc_in;
   logic [8*N-1:0]    env_in;
   logic [N-1:0]      voice_enable;
   logic [15:0]       mix_out;
   logic              mix_valid;
   logic              busy;
   logic              overrun;

   int n_cmp = 0;
   int n_bad = 0;
   int ecnt  = 0;

   voice_vca_mixer #(.NUM_VOICES(N)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sample_strobe (sample_strobe),
      .osc_in        (osc_in),
      .env_in        (env_in),
      .voice_enable  (voice_enable),
      .mix_out       (mix_out),
      .mix_valid     (mix_valid),
      .busy          (busy),
      .overrun       (overrun)
   );

   always #10 clk = ~clk;

   // Reference: floor(osc*env/256) per enabled voice, summed, then clamped.
   function automatic int model(input logic [16*N-1:0] o, input logic [8*N-1:0] e,
                                input logic [N-1:0] en);
      int sum = 0;
      for (int v = 0; v < N; v++) begin
         int ov = int'($signed(o[16*v +: 16]));
         int evv = int'(e[8*v +: 8]);
         int p = ov * evv;
         int q = p / 256;
         if (p < 0 && (p % 256) != 0) q = q - 1;
         if (en[v]) sum += q;
      end
      if (sum > 32767) sum = 32767;
      if (sum < -32768) sum = -32768;
      return sum;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
      $display("check %-14s got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      ecnt++;
   endtask

   task automatic start_pass(input logic [16*N-1:0] o, input logic [8*N-1:0] e,
                             input logic [N-1:0] en);
      osc_in = o;
      env_in = e;
      voice_enable = en;
      sample_strobe = 1'b1;
      @(posedge clk);
      #1;
      sample_strobe = 1'b0;
      ecnt = 0;
   endtask

   task automatic wait_valid(output int lat);
      lat = -1;
      for (int i = 0; i < 200; i++) begin
         step();
         if (mix_valid) begin
            lat = ecnt;
            break;
         end
      end
   endtask

   function automatic logic [16*N-1:0] rand_osc();
      logic [16*N-1:0] r;
      for (int v = 0; v < N; v++) r[16*v +: 16] = 16'($urandom);
      return r;
   endfunction

   logic [16*N-1:0] o_mixed, o_max, o_min, o_r;
   logic [8*N-1:0]  e_mixed, e_full, e_r;
   logic [N-1:0]    en_r;
   int lat, nv, val, exp_v;

   initial begin
      o_max   = {N{16'h7FFF}};
      o_min   = {N{16'h8000}};
      e_full  = {N{8'hFF}};
      o_mixed = {16'h7FFF, 16'hFFFF, 16'hFDA8, 16'h03E8};
      e_mixed = {8'hFF, 8'h01, 8'h40, 8'h80};

      rst_n = 1'b0;
      sample_strobe = 1'b0;
      osc_in = '0;
      env_in = '0;
      voice_enable = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mix_out", int'($signed(mix_out)), 0);
      check("rst_mix_valid", int'(mix_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_overrun", int'(overrun), 0);
      rst_n = 1'b1;
      step();

      // Single full-scale voice, others disabled.
      start_pass(o_max, e_full, 4'b0001);
      check("busy_in_pass", int'(busy), 1);
      wait_valid(lat);
      check("latency_v0", lat, LAT);
      check("mix_v0", int'($signed(mix_out)), 32639);
      check("busy_at_done", int'(busy), 0);
      // Strobe right after mix_valid must be accepted.
      start_pass(o_max, e_full, 4'b1111);
      check("valid_pulse", int'(mix_valid), 0);
      check("mix_hold", int'($signed(mix_out)), 32639);
      wait_valid(lat);
      check("latency_satp", lat, LAT);
      check("mix_sat_pos", int'($signed(mix_out)), 32767);
      start_pass(o_min, e_full, 4'b1111);
      wait_valid(lat);
      check("mix_sat_neg", int'($signed(mix_out)), -32768);
      check("no_overrun", int'(overrun), 0);
      start_pass(o_mixed, e_mixed, 4'b0111);
      wait_valid(lat);
      check("mix_mixed", int'($signed(mix_out)), 349);

      // Input change plus re-strobe at edge 10 of a pass.
      start_pass(o_mixed, e_mixed, 4'b0111);
      repeat (9) step();
      osc_in = o_max;
      env_in = e_full;
      voice_enable = 4'b1111;
      sample_strobe = 1'b1;
      step();
      sample_strobe = 1'b0;
      check("overrun_set", int'(overrun), 1);
      wait_valid(lat);
      check("latency_ovr", lat, LAT);
      check("mix_snapshot", int'($signed(mix_out)), 349);
      nv = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (mix_valid) nv++;
      end
      check("no_2nd_valid", nv, 0);
      check("overrun_sticky", int'(overrun), 1);

      // Asynchronous reset in the middle of a pass.
      start_pass(rand_osc(), 32'($urandom), 4'($urandom));
      repeat (19) step();
      #5;
      rst_n = 1'b0;
      #1;
      check("arst_mix_out", int'($signed(mix_out)), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_overrun", int'(overrun), 0);
      check("arst_valid", int'(mix_valid), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      nv = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (mix_valid) nv++;
      end
      check("arst_no_valid", nv, 0);
      o_r = rand_osc();
      e_r = 32'($urandom);
      en_r = 4'($urandom);
      exp_v = model(o_r, e_r, en_r);
      start_pass(o_r, e_r, en_r);
      wait_valid(lat);
      check("latency_post", lat, LAT);
      check("mix_post_rst", int'($signed(mix_out)), exp_v);

      // Periodic strobes with a ramping envelope.
      for (int p = 0; p < 8; p++) begin
         o_r = rand_osc();
         en_r = 4'($urandom);
         for (int v = 0; v < N; v++) e_r[8*v +: 8] = 8'((p * 32 + v * 9) % 256);
         exp_v = model(o_r, e_r, en_r);
         start_pass(o_r, e_r, en_r);
         osc_in = rand_osc();
         env_in = 32'($urandom);
         nv = 0;
         val = 0;
         lat = -1;
         for (int i = 0; i < 1023; i++) begin
            step();
            if (mix_valid) begin
               nv++;
               val = int'($signed(mix_out));
               lat = ecnt;
            end
         end
         check("per_valids", nv, 1);
         check("per_latency", lat, LAT);
         check("per_mix", val, exp_v);
      end
      check("per_overrun", int'(overrun), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
